disp_seq_ctrl: RTL and testbench

DISP_SEQ_CTRL -- requirements
Module: disp_seq_ctrl

---
 rtl/disp_seq_pkg.sv | 14 +
 rtl/disp_seq_ctrl_frame_edge_det.sv | 23 ++
 rtl/disp_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_disp_seq_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_seq_pkg.sv
// Shared state encoding and constants for the display source sequencer.
package disp_seq_pkg;

    typedef enum logic [2:0] {
        ST_UI         = 3'd0,
        ST_BLK_TO_IMG = 3'd1,
        ST_IMG        = 3'd2,
        ST_BLK_TO_UI  = 3'd3,
        ST_SLEEP      = 3'd4
    } disp_state_t;

    localparam logic [23:0] BLACK = 24'h000000;

endpackage

// File: rtl/disp_seq_ctrl_frame_edge_det.sv
// Frame boundary detector: one-cycle fb pulse when vsync first reaches its asserted level.
module frame_edge_det
    import disp_seq_pkg::*;
#(
    parameter logic VS_POL = 1'b0
) (
    input  logic lcd_clk_33m,
    input  logic rst_n,
    input  logic vsync,
    output logic fb
);

    logic vs_prev;

    // Resetting to the asserted level suppresses a spurious fb right after reset.
    always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
        if (!rst_n) vs_prev <= VS_POL;
        else        vs_prev <= vsync;
    end

    assign fb = (vsync == VS_POL) && (vs_prev != VS_POL);

endmodule

// File: rtl/disp_seq_ctrl.sv
// Display source sequencer: UI/image switching with black-frame blanking,
// idle sleep with backlight off, and activity wake-up, all aligned to frame boundaries.
module disp_seq_ctrl
    import disp_seq_pkg::*;
#(
    parameter int   BLANK_FRAMES = 2,
    parameter int   IDLE_FRAMES  = 1800,
    parameter logic VS_POL       = 1'b0
) (
    input  logic        lcd_clk_33m,
    input  logic        rst_n,
    input  logic        vsync,
    input  logic        mode_req,
    input  logic        activity,
    input  logic [23:0] pix_data_ui,
    input  logic [23:0] pix_data_img,
    output logic [23:0] pix_data,
    output logic        display_mode,
    output logic        blank,
    output logic        lcd_bl_en
);

    localparam logic [3:0]  BLK_LAST  = 4'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);
    localparam logic [11:0] IDLE_LAST = 12'((IDLE_FRAMES > 0) ? IDLE_FRAMES - 1 : 0);
    localparam bit          NO_BLANK  = (BLANK_FRAMES == 0);
    localparam bit          IDLE_EN   = (IDLE_FRAMES > 0);

    logic        fb;
    logic        mode_meta, mode_s;
    disp_state_t state_q, state_d;
    logic [3:0]  blank_cnt_q, blank_cnt_d;
    logic [11:0] idle_cnt_q, idle_cnt_d;
    logic        wake_pend_q, wake_pend_d;
    logic        disp_mode_q, disp_mode_d;

    frame_edge_det #(.VS_POL(VS_POL)) u_frame_edge_det (
        .lcd_clk_33m (lcd_clk_33m),
        .rst_n       (rst_n),
        .vsync       (vsync),
        .fb          (fb)
    );

    always_ff @(posedge lcd_clk_33m or negedge rst_n) begin
        if (!rst_n) begin
            mode_meta   <= 1'b0;
            mode_s      <= 1'b0;
            state_q     <= ST_UI;
            blank_cnt_q <= '0;
            idle_cnt_q  <= '0;
            wake_pend_q <= 1'b0;
            disp_mode_q <= 1'b0;
        end else begin
            mode_meta   <= mode_req;
            mode_s      <= mode_meta;
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            wake_pend_q <= wake_pend_d;
            disp_mode_q <= disp_mode_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        wake_pend_d = wake_pend_q || (activity && (state_q == ST_SLEEP));
        if (fb) begin
            case (state_q)
                ST_UI: begin
                    if (mode_s) begin
                        state_d     = NO_BLANK ? ST_IMG : ST_BLK_TO_IMG;
                        blank_cnt_d = '0;
                    end else if (IDLE_EN && !activity && (idle_cnt_q == IDLE_LAST)) begin
                        state_d = ST_SLEEP;
                    end
                end
                ST_IMG: begin
                    if (!mode_s) begin
                        state_d     = NO_BLANK ? ST_UI : ST_BLK_TO_UI;
                        blank_cnt_d = '0;
                    end else if (IDLE_EN && !activity && (idle_cnt_q == IDLE_LAST)) begin
                        state_d = ST_SLEEP;
                    end
                end
                // Target follows mode_s; the count is never restarted on a retarget,
                // so a reversal mid-blank still yields exactly BLANK_FRAMES black frames.
                ST_BLK_TO_IMG, ST_BLK_TO_UI: begin
                    if (blank_cnt_q == BLK_LAST) begin
                        state_d = mode_s ? ST_IMG : ST_UI;
                    end else begin
                        state_d     = mode_s ? ST_BLK_TO_IMG : ST_BLK_TO_UI;
                        blank_cnt_d = blank_cnt_q + 4'd1;
                    end
                end
                ST_SLEEP: begin
                    if (wake_pend_q || activity) begin
                        state_d     = mode_s ? ST_IMG : ST_UI;
                        wake_pend_d = 1'b0;
                    end
                end
                default: state_d = ST_UI;
            endcase
        end
    end

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (activity || (state_d != state_q)) begin
            idle_cnt_d = '0;
        end else if (fb && ((state_q == ST_UI) || (state_q == ST_IMG)) && (idle_cnt_q != '1)) begin
            idle_cnt_d = idle_cnt_q + 12'd1;
        end
    end

    always_comb begin
        case (state_d)
            ST_IMG, ST_BLK_TO_UI: disp_mode_d = 1'b1;
            ST_UI, ST_BLK_TO_IMG: disp_mode_d = 1'b0;
            default:              disp_mode_d = disp_mode_q;
        endcase
    end

    assign display_mode = disp_mode_q;
    assign blank        = (state_q == ST_BLK_TO_IMG) || (state_q == ST_BLK_TO_UI) ||
                          (state_q == ST_SLEEP);
    assign lcd_bl_en    = (state_q != ST_SLEEP);

    always_comb begin
        if (blank)             pix_data = BLACK;
        else if (display_mode) pix_data = pix_data_img;
        else                   pix_data = pix_data_ui;
    end

endmodule

// File: tb/tb_disp_seq_ctrl.sv
// Directed scoreboard bench for disp_seq_ctrl (blanking, retarget, sleep/wake, reset, zero-blank).
module tb_disp_seq_ctrl;

    typedef struct {
        string       tag;
        logic        dm;
        logic        blank;
        logic        bl_en;
        logic [23:0] pix;
        logic        dm_b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, vsync, mode_req, activity;
    logic [23:0] pix_ui, pix_img;
    logic [23:0] pix_a, pix_b;
    logic        dm_a, blank_a, bl_a;
    logic        dm_b, blank_b, bl_b;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    disp_seq_ctrl #(.BLANK_FRAMES(2), .IDLE_FRAMES(3), .VS_POL(1'b0)) u_dut_a (
        .lcd_clk_33m  (clk),
        .rst_n        (rst_n),
        .vsync        (vsync),
        .mode_req     (mode_req),
        .activity     (activity),
        .pix_data_ui  (pix_ui),
        .pix_data_img (pix_img),
        .pix_data     (pix_a),
        .display_mode (dm_a),
        .blank        (blank_a),
        .lcd_bl_en    (bl_a)
    );

    disp_seq_ctrl #(.BLANK_FRAMES(0), .IDLE_FRAMES(0), .VS_POL(1'b0)) u_dut_b (
        .lcd_clk_33m  (clk),
        .rst_n        (rst_n),
        .vsync        (vsync),
        .mode_req     (mode_req),
        .activity     (activity),
        .pix_data_ui  (pix_ui),
        .pix_data_img (pix_img),
        .pix_data     (pix_b),
        .display_mode (dm_b),
        .blank        (blank_b),
        .lcd_bl_en    (bl_b)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic dm, input logic bk,
                              input logic be, input logic dmb);
        exp_t e;
        e.tag   = tag;
        e.dm    = dm;
        e.blank = bk;
        e.bl_en = be;
        e.pix   = bk ? 24'h000000 : (dm ? pix_img : pix_ui);
        e.dm_b  = dmb;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL sb_empty got=%0d exp>0", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            assert (dm_a === e.dm) else begin
                bad++; $error("FAIL %s.display_mode got=%0b exp=%0b", e.tag, dm_a, e.dm);
            end
            total++;
            assert (blank_a === e.blank) else begin
                bad++; $error("FAIL %s.blank got=%0b exp=%0b", e.tag, blank_a, e.blank);
            end
            total++;
            assert (bl_a === e.bl_en) else begin
                bad++; $error("FAIL %s.lcd_bl_en got=%0b exp=%0b", e.tag, bl_a, e.bl_en);
            end
            total++;
            assert (pix_a === e.pix) else begin
                bad++; $error("FAIL %s.pix_data got=%h exp=%h", e.tag, pix_a, e.pix);
            end
            total++;
            assert (dm_b === e.dm_b) else begin
                bad++; $error("FAIL %s.b_display_mode got=%0b exp=%0b", e.tag, dm_b, e.dm_b);
            end
            total++;
            assert (blank_b === 1'b0) else begin
                bad++; $error("FAIL %s.b_blank got=%0b exp=0", e.tag, blank_b);
            end
        end
    endtask

    // One ~1000-cycle frame: optional mid-frame mode change/activity, then an fb edge
    // (optionally with activity in the same cycle), then compare against expectations.
    task automatic frame(input logic act, input logic fb_act, input logic chg, input logic mval,
                         input string tag, input logic dm, input logic bk, input logic be,
                         input logic dmb);
        vsync = 1'b1;
        cyc(500);
        if (chg) mode_req = mval;
        if (act) begin
            activity = 1'b1;
            cyc(1);
            activity = 1'b0;
        end
        cyc(490);
        pix_ui  = 24'($urandom);
        pix_img = 24'($urandom);
        cyc(5);
        expect_out(tag, dm, bk, be, dmb);
        vsync    = 1'b0;
        activity = fb_act;
        cyc(1);
        vsync    = 1'b1;
        activity = 1'b0;
        check_out();
    endtask

    initial begin
        rst_n    = 1'b0;
        vsync    = 1'b1;
        mode_req = 1'b0;
        activity = 1'b0;
        pix_ui   = 24'h123456;
        pix_img  = 24'hABCDEF;
        cyc(3);
        expect_out("reset", 1'b0, 1'b0, 1'b1, 1'b0);
        check_out();
        rst_n = 1'b1;
        cyc(2);

        // UI -> image with two black frames; zero-blank instance switches at once
        frame(1, 0, 0, 0, "ui_fb0",      0, 0, 1, 0);
        frame(1, 0, 1, 1, "sw_img_blk1", 0, 1, 1, 1);
        frame(1, 0, 0, 0, "sw_img_blk2", 0, 1, 1, 1);
        frame(1, 0, 0, 0, "sw_img_show", 1, 0, 1, 1);
        frame(1, 0, 1, 0, "sw_ui_blk1",  1, 1, 1, 0);
        frame(1, 0, 0, 0, "sw_ui_blk2",  1, 1, 1, 0);
        frame(1, 0, 0, 0, "sw_ui_show",  0, 0, 1, 0);

        // Reversal after the first black frame: no image frame is ever shown
        frame(1, 0, 1, 1, "abort_blk1",  0, 1, 1, 1);
        frame(1, 0, 1, 0, "abort_retgt", 1, 1, 1, 0);
        frame(1, 0, 0, 0, "abort_ui",    0, 0, 1, 0);

        // Idle timeout and wake by activity
        frame(0, 0, 0, 0, "idle1", 0, 0, 1, 0);
        frame(0, 0, 0, 0, "idle2", 0, 0, 1, 0);
        frame(0, 0, 0, 0, "sleep", 0, 1, 0, 0);
        frame(1, 0, 0, 0, "wake",  0, 0, 1, 0);

        // Activity coincident with the third idle fb prevents sleep and clears the count
        frame(0, 0, 0, 0, "d_idle1",    0, 0, 1, 0);
        frame(0, 0, 0, 0, "d_idle2",    0, 0, 1, 0);
        frame(0, 1, 0, 0, "act_at_fb",  0, 0, 1, 0);
        frame(0, 0, 0, 0, "d_post1",    0, 0, 1, 0);
        frame(0, 0, 0, 0, "d_post2",    0, 0, 1, 0);
        frame(0, 0, 0, 0, "d_sleep",    0, 1, 0, 0);
        frame(0, 1, 0, 0, "wake_at_fb", 0, 0, 1, 0);

        // Reset in the middle of blanking, released with vsync held asserted
        frame(1, 0, 1, 1, "pre_rst_blk", 0, 1, 1, 1);
        cyc(300);
        #2 rst_n = 1'b0;
        #1;
        expect_out("rst_mid", 1'b0, 1'b0, 1'b1, 1'b0);
        check_out();
        @(negedge clk);
        mode_req = 1'b0;
        vsync    = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(4);
        frame(0, 0, 0, 0, "post_rst1",  0, 0, 1, 0);
        frame(0, 0, 0, 0, "post_rst2",  0, 0, 1, 0);
        frame(0, 0, 0, 0, "post_rst3",  0, 1, 0, 0);
        frame(1, 0, 0, 0, "post_wake",  0, 0, 1, 0);

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_leftover got=%0d exp=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
